// File: rtl/run_det_pkg.sv
// Shared types for the run-length detector: FSM state encoding and width.
package run_det_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_ONES  = 3'd1,
        S_ZEROS = 3'd2,
        S_HIT1  = 3'd3,
        S_HIT0  = 3'd4
    } run_state_t;

    function automatic logic is_hit(input run_state_t s);
        return (s == S_HIT1) || (s == S_HIT0);
    endfunction

endpackage

// File: rtl/run_detector_if.sv
// Sample/control inputs and status outputs of run_detector, grouped as one bus.
interface run_detector_if
    import run_det_pkg::*;
#(
    parameter int CNT_W = 4,
    parameter int EVT_W = 8
);
    logic               en;
    logic               w;
    logic               clr;
    logic               z;
    logic               z_rise;
    logic               run_val;
    logic [CNT_W-1:0]   run_len;
    logic [STATE_W-1:0] state;
    logic [EVT_W-1:0]   evt_cnt;

    modport master (
        output en, w, clr,
        input  z, z_rise, run_val, run_len, state, evt_cnt
    );

    modport slave (
        input  en, w, clr,
        output z, z_rise, run_val, run_len, state, evt_cnt
    );
endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter with clear > load-to-one > increment priority.
module sat_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load1,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load1) begin
            cnt_d = W'(1);
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/run_detector.sv
// Run-length detector: five-state FSM plus saturating run counter.
// Optional event counter enabled by defining RUN_DETECTOR_EVT_CNT_EN.
module run_detector
    import run_det_pkg::*;
#(
    parameter int ONES_LEN  = 4,
    parameter int ZEROS_LEN = 4,
    parameter int CNT_W     = 4,
    parameter int EVT_W     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    run_detector_if.slave  bus
);
    // state | meaning
    // S_IDLE  | no sample taken yet (or cleared)
    // S_ONES  | ones run below ONES_LEN
    // S_ZEROS | zeros run below ZEROS_LEN
    // S_HIT1  | ones run at or above ONES_LEN
    // S_HIT0  | zeros run at or above ZEROS_LEN

    if (CNT_W < 1 || ONES_LEN < 1 || ONES_LEN > (2**CNT_W) - 1) begin : g_bad_ones
        $error("run_detector: ONES_LEN out of range for CNT_W");
    end
    if (ZEROS_LEN < 1 || ZEROS_LEN > (2**CNT_W) - 1) begin : g_bad_zeros
        $error("run_detector: ZEROS_LEN out of range for CNT_W");
    end
    if (EVT_W < 1) begin : g_bad_evt
        $error("run_detector: EVT_W must be at least 1");
    end

    localparam logic [CNT_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] ONES_TH = CNT_W'(ONES_LEN);
    localparam logic [CNT_W-1:0] ZERO_TH = CNT_W'(ZEROS_LEN);

    run_state_t       state_q, state_d;
    logic             z_q, z_d;
    logic             z_rise_q, z_rise_d;
    logic             run_val_q, run_val_d;
    logic             len_inc, len_load1, cont;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] len_new;

    always_comb begin
        state_d   = state_q;
        run_val_d = run_val_q;
        z_rise_d  = 1'b0;
        len_inc   = 1'b0;
        len_load1 = 1'b0;
        cont      = 1'b0;
        len_new   = run_len;
        if (bus.clr) begin
            state_d   = S_IDLE;
            run_val_d = 1'b0;
        end else if (bus.en) begin
            cont = bus.w ? (state_q == S_ONES  || state_q == S_HIT1)
                         : (state_q == S_ZEROS || state_q == S_HIT0);
            // Mirror the counter's next value so the threshold sees the new length.
            if (cont) begin
                len_inc = 1'b1;
                len_new = (run_len == LEN_MAX) ? LEN_MAX : run_len + 1'b1;
            end else begin
                len_load1 = 1'b1;
                len_new   = CNT_W'(1);
            end
            run_val_d = bus.w;
            if (bus.w) begin
                state_d = (len_new >= ONES_TH) ? S_HIT1 : S_ONES;
            end else begin
                state_d = (len_new >= ZERO_TH) ? S_HIT0 : S_ZEROS;
            end
            z_rise_d = is_hit(state_d) && (state_d != state_q);
        end
        z_d = is_hit(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            z_q       <= 1'b0;
            z_rise_q  <= 1'b0;
            run_val_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            z_q       <= z_d;
            z_rise_q  <= z_rise_d;
            run_val_q <= run_val_d;
        end
    end

    sat_cnt #(.W(CNT_W)) u_run_len (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (len_inc),
        .load1 (len_load1),
        .clr   (bus.clr),
        .cnt   (run_len)
    );

`ifdef RUN_DETECTOR_EVT_CNT_EN
    sat_cnt #(.W(EVT_W)) u_evt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (z_rise_d),
        .load1 (1'b0),
        .clr   (1'b0),
        .cnt   (bus.evt_cnt)
    );
`else
    assign bus.evt_cnt = '0;
`endif

    assign bus.z       = z_q;
    assign bus.z_rise  = z_rise_q;
    assign bus.run_val = run_val_q;
    assign bus.run_len = run_len;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_run_detector.sv
// Directed self-checking bench for run_detector (default and threshold-1 builds).
module tb_run_detector;
    import run_det_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    run_detector_if #(.CNT_W(4), .EVT_W(8)) bus  ();
    run_detector_if #(.CNT_W(4), .EVT_W(8)) bus1 ();

    run_detector #(.ONES_LEN(4), .ZEROS_LEN(4), .CNT_W(4), .EVT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    run_detector #(.ONES_LEN(1), .ZEROS_LEN(1), .CNT_W(4), .EVT_W(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic e, input logic wv, input logic c);
        bus.en  = e;
        bus.w   = wv;
        bus.clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step1(input logic e, input logic wv);
        bus1.en  = e;
        bus1.w   = wv;
        bus1.clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b0; bus.w = 1'b0; bus.clr = 1'b0;
        bus1.en = 1'b0; bus1.w = 1'b0; bus1.clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.z, bus.z_rise, bus.run_val, bus.run_len, bus.state, bus.evt_cnt} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h exp=0",
                     {bus.z, bus.z_rise, bus.run_val, bus.run_len, bus.state, bus.evt_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ones_detect();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b1, 1'b0);
            total++;
            if (bus.z !== (i == 4) || bus.z_rise !== (i == 4) || bus.run_len !== 4'(i)) begin
                bad++;
                $display("FAIL ones_step%0d got z=%0b rise=%0b len=%0d exp z=%0b rise=%0b len=%0d",
                         i, bus.z, bus.z_rise, bus.run_len, (i == 4), (i == 4), i);
            end
            total++;
            if (bus.state !== ((i == 4) ? 3'd3 : 3'd1) || bus.run_val !== 1'b1) begin
                bad++;
                $display("FAIL ones_state%0d got st=%0d val=%0b", i, bus.state, bus.run_val);
            end
        end
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (bus.z !== 1'b1 || bus.z_rise !== 1'b0 || bus.state !== 3'd3) begin
            bad++;
            $display("FAIL ones_hold got z=%0b rise=%0b st=%0d exp z=1 rise=0 st=3",
                     bus.z, bus.z_rise, bus.state);
        end
    endtask

    task automatic test_zeros_detect();
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (bus.z !== 1'b0 || bus.state !== 3'd2 || bus.run_len !== 4'd1 || bus.run_val !== 1'b0) begin
            bad++;
            $display("FAIL zeros_first got z=%0b st=%0d len=%0d val=%0b exp z=0 st=2 len=1 val=0",
                     bus.z, bus.state, bus.run_len, bus.run_val);
        end
        for (int i = 2; i <= 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            total++;
            if (bus.z !== (i == 4) || bus.z_rise !== (i == 4) ||
                bus.state !== ((i == 4) ? 3'd4 : 3'd2) || bus.run_len !== 4'(i)) begin
                bad++;
                $display("FAIL zeros_step%0d got z=%0b rise=%0b st=%0d len=%0d",
                         i, bus.z, bus.z_rise, bus.state, bus.run_len);
            end
        end
    endtask

    task automatic test_en_gating();
        logic [5:0] en_pat;
        int k;
        en_pat = 6'b111001;
        step(1'b0, 1'b0, 1'b1);
        total++;
        if (bus.state !== 3'd0 || bus.run_len !== 4'd0) begin
            bad++;
            $display("FAIL gate_clr got st=%0d len=%0d exp st=0 len=0", bus.state, bus.run_len);
        end
        k = 0;
        for (int i = 0; i < 6; i++) begin
            if (en_pat[i]) k++;
            step(en_pat[i], 1'b1, 1'b0);
            total++;
            if (bus.run_len !== 4'(k) || bus.z !== (k >= 4) || bus.z_rise !== (en_pat[i] && k == 4)) begin
                bad++;
                $display("FAIL gate_step%0d got len=%0d z=%0b rise=%0b exp len=%0d z=%0b rise=%0b",
                         i, bus.run_len, bus.z, bus.z_rise, k, (k >= 4), (en_pat[i] && k == 4));
            end
        end
    endtask

    task automatic test_saturation();
        int pulses;
        int exp_len;
        pulses = 0;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (bus.z_rise === 1'b1) pulses++;
            exp_len = (i > 15) ? 15 : i;
            total++;
            if (bus.run_len !== 4'(exp_len) || bus.z !== (i >= 4)) begin
                bad++;
                $display("FAIL sat_step%0d got len=%0d z=%0b exp len=%0d z=%0b",
                         i, bus.run_len, bus.z, exp_len, (i >= 4));
            end
        end
        total++;
        if (pulses !== 1 || bus.state !== 3'd3) begin
            bad++;
            $display("FAIL sat_pulses got pulses=%0d st=%0d exp pulses=1 st=3", pulses, bus.state);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.z, bus.z_rise, bus.run_val, bus.run_len, bus.state} !== 11'd0) begin
            bad++;
            $display("FAIL async_reset got=%0h exp=0",
                     {bus.z, bus.z_rise, bus.run_val, bus.run_len, bus.state});
        end
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clr_priority();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        total++;
        if (bus.state !== 3'd0 || bus.run_len !== 4'd0 || bus.run_val !== 1'b0 ||
            bus.z !== 1'b0 || bus.z_rise !== 1'b0) begin
            bad++;
            $display("FAIL clr_priority got st=%0d len=%0d val=%0b z=%0b rise=%0b exp all 0",
                     bus.state, bus.run_len, bus.run_val, bus.z, bus.z_rise);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_len1_alternate();
        logic [7:0] exp_evt;
        logic       wv;
        for (int i = 0; i < 6; i++) begin
            wv = (i % 2 == 0);
            step1(1'b1, wv);
            total++;
            if (bus1.z !== 1'b1 || bus1.z_rise !== 1'b1 || bus1.run_len !== 4'd1 ||
                bus1.state !== (wv ? 3'd3 : 3'd4)) begin
                bad++;
                $display("FAIL len1_step%0d got z=%0b rise=%0b len=%0d st=%0d",
                         i, bus1.z, bus1.z_rise, bus1.run_len, bus1.state);
            end
        end
        step1(1'b0, 1'b0);
`ifdef RUN_DETECTOR_EVT_CNT_EN
        exp_evt = 8'd6;
`else
        exp_evt = 8'd0;
`endif
        total++;
        if (bus1.evt_cnt !== exp_evt || bus1.z_rise !== 1'b0) begin
            bad++;
            $display("FAIL len1_evt got evt=%0d rise=%0b exp evt=%0d rise=0",
                     bus1.evt_cnt, bus1.z_rise, exp_evt);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ones_detect();
        test_zeros_detect();
        test_en_gating();
        test_saturation();
        test_async_reset();
        test_clr_priority();
        test_len1_alternate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/run_detector.md
# run_detector

Parametrised run-length detector for a single-bit serial input. It watches sampled bits of `w` and raises `z` once the current run of equal bits reaches a per-polarity threshold: `ONES_LEN` for ones, `ZEROS_LEN` for zeros. It replaces hard-coded per-length state chains with a five-state FSM plus a saturating run counter. It sits between a debounced switch/serial source and board LEDs or downstream control logic.

## Interface
- `ONES_LEN`, default 4: consecutive ones required for detection; range 1 .. 2**CNT_W-1.
- `ZEROS_LEN`, default 4: consecutive zeros required for detection; same range.
- `CNT_W`, default 4: width of `run_len`.
- `EVT_W`, default 8: width of `evt_cnt`.
- Out-of-range parameters are an elaboration error.

Ports (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  sample strobe; `w` is consumed only on edges where `en`=1.
- `w`  in  1  serial input bit.
- `clr`  in  1  synchronous clear; has priority over `en`.
- `z`  out  1  detection level.
- `z_rise`  out  1  one-cycle pulse on each entry into a hit state.
- `run_val`  out  1  polarity of the current run.
- `run_len`  out  CNT_W  length of the current run, saturating.
- `state`  out  3  FSM state, for LEDs and debug.
- `evt_cnt`  out  EVT_W  detection event count (see Configuration).

## Operation
- States:
  - `S_IDLE`=0: no sample yet.
  - `S_ONES`=1: ones run, below threshold.
  - `S_ZEROS`=2: zeros run, below threshold.
  - `S_HIT1`=3: ones run at or above `ONES_LEN`.
  - `S_HIT0`=4: zeros run at or above `ZEROS_LEN`.
- On a sample with `w`=1:
  - From `S_IDLE`, `S_ZEROS` or `S_HIT0`: set `run_len`=1, `run_val`=1, next state `S_HIT1` if `ONES_LEN`==1, else `S_ONES`.
  - From `S_ONES` or `S_HIT1`: `run_len` increments and saturates at 2**CNT_W-1. Next state is `S_HIT1` if the new length is >= `ONES_LEN`.
- A sample with `w`=0 behaves symmetrically, using `ZEROS_LEN`, `S_ZEROS` and `S_HIT0`.
- Output decode:
  - `z` = (`state`==`S_HIT1`) or (`state`==`S_HIT0`).
  - `z_rise` = 1 for one cycle after any edge that moves the FSM into `S_HIT1` or `S_HIT0` from a different state. This includes `S_HIT1`→`S_HIT0` directly when a threshold is 1.
  - Staying in a hit state never re-pulses `z_rise`.
- With `en`=0, all registers hold and `z_rise`=0.
- With `clr`=1: state=`S_IDLE`, `run_len`=0, `run_val`=0, `z_rise`=0. `evt_cnt` is not cleared by `clr`.
- Saturation: `run_len` holds at its maximum. `z` stays asserted, with no wrap and no false re-detection.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: the sample taken at edge k is reflected on the outputs after edge k. With `ONES_LEN`=4, `z` is high in the cycle after the 4th qualifying sample edge.
- Reset: `rst_n` low immediately forces all outputs to 0 and state to `S_IDLE`. This applies mid-run as well, with no clock needed.
- Simultaneous `clr` and `en`: `clr` wins and the sample is discarded.

## Configuration
- Macro `RUN_DETECTOR_EVT_CNT_EN`.
- Defined: `evt_cnt` increments on every `z_rise` event and saturates at 2**EVT_W-1. It clears only on `rst_n`.
- Undefined: the port remains present and is tied to 0, and no counter logic is instantiated.

## Structure
- Package `run_det_pkg`:
  - the state enum `run_state_t`, 3 bits, with the encodings above;
  - the `S_*` constants;
  - the `STATE_W`=3 localparam.
- Sub-module `sat_cnt`: a parametrised-width saturating counter with `inc`, `load1` and `clr` inputs. It is used for `run_len` and, when enabled, for `evt_cnt`.

## Test plan
- Reset, then `w`=1 with `en`=1 for 4 edges → `z`=0 after samples 1–3 and `z`=1 after the 4th; `z_rise` pulses once; `run_len`=4; `state`=3.
- From `S_HIT1`, apply `w`=0 for one sample → `z`=0, `state`=2, `run_len`=1, `run_val`=0. Three more zeros → `z`=1, `state`=4.
- `w`=1 held with `en` pattern 1,0,0,1,1,1 → detection only after the 4th enabled edge; `run_len` is unchanged during the `en`=0 cycles.
- `CNT_W`=4, 20 consecutive ones → `run_len` saturates at 15, `z` stays 1, `z_rise` occurs exactly once.
- `rst_n` pulsed low between clock edges mid-run → all outputs 0 immediately. `clr`=1 together with `en`=1, `w`=1 → `state`=0, `run_len`=0.
- `ONES_LEN`=`ZEROS_LEN`=1 with alternating `w` over 6 samples, macro defined → `z` stays 1, `z_rise` pulses every sample, `evt_cnt`=6.
